// File: rtl/enc164_req_encoder.sv
// enc164_req_encoder: sequential 16-to-4 request encoder.
//
// Captures 16 request lines into a sticky pending register and presents one
// pending request at a time as a 4-bit code with a valid/ack handshake. The
// presented request is cleared from the pending register when acknowledged.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous, active-high reset
//   enable   in   1   when low, all state holds and req/ack are ignored
//   req      in  16   request lines, bit i requests code i
//   ack      in   1   consumer accepts the presented code (only while valid)
//   code     out  4   index of the presented request (registered)
//   valid    out  1   code is meaningful (registered)
//   pending  out 16   sticky pending register (registered)
//
// Optional feature macro: ENC_ROUND_ROBIN_EN
//   defined   -> rotating priority starting at a pointer advanced on each ack
//   undefined -> fixed priority, lowest set index wins
module enc164_req_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] req,
  input  logic        ack,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pending
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  code_q, code_d;

  logic [15:0] clr;
  logic [15:0] pend_nx;
  logic [3:0]  base;
  logic [3:0]  idx;
  logic [3:0]  sel;
  logic        found;
  logic        accept;

  assign accept = (state_q == S_PRESENT) && ack;

`ifdef ENC_ROUND_ROBIN_EN
  logic [3:0] ptr_q, ptr_d;

  // The pointer moves on the same edge as the ack, and the selection made on
  // that edge already uses the moved pointer, so a held request alternates.
  always_comb begin
    ptr_d = ptr_q;
    if (enable && accept) begin
      ptr_d = code_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign base = ptr_d;
`else
  assign base = '0;
`endif

  always_comb begin
    clr = '0;
    if (accept) begin
      clr[code_q] = 1'b1;
    end
    // A new request on the acked bit re-sets it.
    pend_nx = (pending_q & ~clr) | req;

    // Cyclic search from base; 4-bit index arithmetic wraps 15 -> 0.
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = base + k[3:0];
      if (!found && pend_nx[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end

    pending_d = pending_q;
    code_d    = code_q;
    state_d   = state_q;
    if (enable) begin
      pending_d = pend_nx;
      if ((state_q == S_IDLE) || ack) begin
        if (pend_nx != '0) begin
          code_d  = sel;
          state_d = S_PRESENT;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
    end
  end

  assign code    = code_q;
  assign valid   = (state_q == S_PRESENT);
  assign pending = pending_q;

endmodule

// File: tb/tb_enc164_req_encoder.sv
module tb_enc164_req_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] req = '0;
  logic        ack = 1'b0;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;

  enc164_req_encoder dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  always #5 clk = ~clk;

`ifdef ENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        ack;
    logic [3:0]  code;
    logic        valid;
    logic [15:0] pend;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference: pending set as a bit vector, code/ptr as integers.
  logic [15:0] m_p = '0;
  int          m_code = 0;
  bit          m_valid = 1'b0;
  int          m_ptr = 0;

  function automatic vec_t mk(logic rst, logic en, logic [15:0] r, logic a,
                              logic [3:0] c, logic v, logic [15:0] p);
    vec_t t;
    t.rst = rst; t.en = en; t.req = r; t.ack = a;
    t.code = c; t.valid = v; t.pend = p;
    return t;
  endfunction

  task automatic model_step(input logic rst, input logic en,
                            input logic [15:0] r, input logic a);
    logic [15:0] pn;
    int          np;
    if (rst) begin
      m_p = '0; m_code = 0; m_valid = 1'b0; m_ptr = 0;
    end else if (en) begin
      pn = m_p;
      np = m_ptr;
      if (m_valid && a) begin
        pn[m_code] = 1'b0;
        if (RR) np = (m_code + 1) % 16;
      end
      pn = pn | r;
      if (!m_valid || a) begin
        if (pn != 0) begin
          for (int k = 0; k < 16; k++) begin
            if (pn[(np + k) % 16]) begin
              m_code = (np + k) % 16;
              break;
            end
          end
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_p = pn;
      m_ptr = np;
    end
  endtask

  task automatic drive(input logic rst, input logic en,
                       input logic [15:0] r, input logic a);
    reset = rst; enable = en; req = r; ack = a;
    @(posedge clk);
    #1;
    model_step(rst, en, r, a);
  endtask

  task automatic check(input string name, input logic [3:0] ec,
                       input logic ev, input logic [15:0] ep);
    n_vec++;
    if (code !== ec || valid !== ev || pending !== ep) begin
      n_err++;
      $display("FAIL %s: got code=%0d valid=%0b pending=%h, want code=%0d valid=%0b pending=%h",
               name, code, valid, pending, ec, ev, ep);
    end
  endtask

  vec_t tbl[20];

  initial begin
    logic [3:0] mc;
    logic       r_rst, r_en, r_ack;
    logic [15:0] r_req;

    // Reset / single pulse / priority drain / hold / enable / mid-op reset.
    tbl[0]  = mk(1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd0,  1'b0, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd0,  1'b0, 16'h0000);
    tbl[2]  = mk(1'b0, 1'b1, 16'h0001, 1'b0, 4'd0,  1'b1, 16'h0001);
    tbl[3]  = mk(1'b0, 1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000);
    tbl[4]  = mk(1'b0, 1'b1, 16'h8010, 1'b0, 4'd4,  1'b1, 16'h8010);
    tbl[5]  = mk(1'b0, 1'b1, 16'h0000, 1'b1, 4'd15, 1'b1, 16'h8000);
    tbl[6]  = mk(1'b0, 1'b1, 16'h0000, 1'b1, 4'd15, 1'b0, 16'h0000);
    tbl[7]  = mk(1'b0, 1'b1, 16'h0010, 1'b0, 4'd4,  1'b1, 16'h0010);
    tbl[8]  = mk(1'b0, 1'b1, 16'h0002, 1'b0, 4'd4,  1'b1, 16'h0012);
    tbl[9]  = mk(1'b0, 1'b1, 16'h0000, 1'b0, 4'd4,  1'b1, 16'h0012);
    tbl[10] = mk(1'b0, 1'b1, 16'h0002, 1'b0, 4'd4,  1'b1, 16'h0012);
    tbl[11] = mk(1'b0, 1'b1, 16'h0000, 1'b0, 4'd4,  1'b1, 16'h0012);
    tbl[12] = mk(1'b0, 1'b1, 16'h0000, 1'b0, 4'd4,  1'b1, 16'h0012);
    tbl[13] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 4'd1,  1'b1, 16'h0002);
    tbl[14] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 4'd1,  1'b0, 16'h0000);
    tbl[15] = mk(1'b0, 1'b1, 16'h0100, 1'b0, 4'd8,  1'b1, 16'h0100);
    tbl[16] = mk(1'b0, 1'b0, 16'hFFFF, 1'b1, 4'd8,  1'b1, 16'h0100);
    tbl[17] = mk(1'b0, 1'b0, 16'hFFFF, 1'b1, 4'd8,  1'b1, 16'h0100);
    tbl[18] = mk(1'b1, 1'b0, 16'hFFFF, 1'b1, 4'd0,  1'b0, 16'h0000);
    tbl[19] = mk(1'b0, 1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].ack);
      check($sformatf("table[%0d]", i), tbl[i].code, tbl[i].valid, tbl[i].pend);
    end

    // Starvation: both requests held with ack held high.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 16'h0003, 1'b1);
      check($sformatf("starve[%0d]", i), (RR && (i % 2 == 1)) ? 4'd1 : 4'd0,
            1'b1, 16'h0003);
    end
    drive(1'b1, 1'b1, 16'h0000, 1'b0);
    check("starve_reset", 4'd0, 1'b0, 16'h0000);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_en  = ($urandom_range(0, 7) != 0);
      r_req = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) r_req = '0;
      r_ack = ($urandom_range(0, 2) != 0);
      drive(r_rst, r_en, r_req, r_ack);
      mc = m_code[3:0];
      check($sformatf("rand[%0d]", i), mc, m_valid, m_p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
